// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder/subtractor, LSB first through one full-adder cell with a registered carry
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_acc;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic             w_s;
    logic             w_c;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_nx;

    // Full-adder cell on the operand LSBs; the new sum bit enters the accumulator at the MSB
    always_comb begin
        w_s      = r_sa[0] ^ r_sb[0] ^ r_c;
        w_c      = (r_sa[0] & r_sb[0]) | (r_c & (r_sa[0] ^ r_sb[0]));
        w_acc_nx = (r_acc >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
        w_last   = r_cnt == CW'(WIDTH - 1);
    end

    // Control FSM and datapath; on the last bit r_c still holds the carry into the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_acc   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= mode ? ~b : b;
                        r_c     <= mode | cin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_acc <= w_acc_nx;
                    r_c   <= w_c;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        sum     <= w_acc_nx;
                        cout    <= w_c;
                        ovf     <= r_c ^ w_c;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
